clk_gen_multi: RTL

CLK_GEN_MULTI -- requirements
Module: clk_gen_multi

---
 rtl/clk_gen_multi.sv | 114 +++++++++++
 1 files changed

// File: rtl/clk_gen_multi.sv
// Multi-channel programmable clock divider with glitch-free divisor updates at period boundaries.
// Optional channel realignment via i_sync is compiled in only when CLK_GEN_SYNC_EN is defined.
module clk_gen_multi #(
    parameter int CHANNELS    = 2,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 32,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                i_clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] i_en,
    input  logic                i_div_valid,
    input  logic [CH_W-1:0]     i_div_ch,
    input  logic [DIV_W-1:0]    i_div_value,
    output logic                o_div_ready,
    output logic                o_div_err,
    input  logic                i_sync,
    output logic [CHANNELS-1:0] o_clk,
    output logic [CHANNELS-1:0] o_tick
);

    logic [CHANNELS-1:0] w_pend;
    logic                w_ready;
    logic                w_ch_ok;
    logic                w_accept;
    logic                w_legal;
    logic                w_sync;
    logic                r_div_err;

`ifdef CLK_GEN_SYNC_EN
    assign w_sync = i_sync;
`else
    logic w_unused_sync;
    assign w_unused_sync = i_sync;
    assign w_sync        = 1'b0;
`endif

    assign w_ch_ok = 32'(i_div_ch) < 32'(CHANNELS);

    // Out-of-range channel reads ready so a stray load never stalls the requester.
    always_comb begin
        w_ready = 1'b1;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (32'(i_div_ch) == 32'(ch)) begin
                w_ready = !w_pend[ch];
            end
        end
    end

    assign o_div_ready = w_ready;
    assign w_accept    = i_div_valid && w_ready && w_ch_ok;
    assign w_legal     = i_div_value >= DIV_W'(2);

    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            r_div_err <= 1'b0;
        end else begin
            r_div_err <= w_accept && !w_legal;
        end
    end

    assign o_div_err = r_div_err;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [DIV_W-1:0] r_div;
        logic [DIV_W-1:0] r_cnt;
        logic [DIV_W-1:0] r_pdiv;
        logic             r_pend;
        logic             r_clk;
        logic             r_tick;
        logic [DIV_W-1:0] w_cnt_inc;
        logic             w_wrap;
        logic             w_load;

        assign w_cnt_inc = r_cnt + DIV_W'(1);
        assign w_wrap    = (r_cnt == r_div - DIV_W'(1));
        assign w_load    = w_accept && w_legal && (32'(i_div_ch) == 32'(g));

        // A load is only accepted while nothing is pending, so it never collides with an apply.
        always_ff @(posedge i_clk or posedge rst) begin
            if (rst) begin
                r_div  <= DIV_W'(DEFAULT_DIV);
                r_cnt  <= '0;
                r_pdiv <= '0;
                r_pend <= 1'b0;
                r_clk  <= 1'b0;
                r_tick <= 1'b0;
            end else begin
                if (!i_en[g] || w_sync || w_wrap) begin
                    r_cnt  <= '0;
                    r_clk  <= 1'b0;
                    r_tick <= 1'b0;
                    if (r_pend) begin
                        r_div  <= r_pdiv;
                        r_pend <= 1'b0;
                    end
                end else begin
                    r_cnt  <= w_cnt_inc;
                    r_clk  <= w_cnt_inc >= (r_div - (r_div >> 1));
                    r_tick <= w_cnt_inc == (r_div - DIV_W'(1));
                end
                if (w_load) begin
                    r_pdiv <= i_div_value;
                    r_pend <= 1'b1;
                end
            end
        end

        assign w_pend[g] = r_pend;
        assign o_clk[g]  = r_clk;
        assign o_tick[g] = r_tick;
    end

endmodule
